// File: rtl/rs_pkg.sv
// Shared reservation-station types: entry layout, issue-register layout and
// the field widths common to the ALU and LSB stations.
package rs_pkg;

    localparam int unsigned RS_OP_W   = 6;
    localparam int unsigned RS_TAG_W  = 4;
    localparam int unsigned RS_DATA_W = 32;

    // One waiting instruction: fields plus per-operand value-or-producer-tag.
    typedef struct packed {
        logic [RS_OP_W-1:0]   op;
        logic [RS_DATA_W-1:0] imm;
        logic [RS_DATA_W-1:0] pc;
        logic [RS_TAG_W-1:0]  des;
        logic                 bp;
        logic                 src1_valid;
        logic [RS_TAG_W-1:0]  src1_tag;
        logic [RS_DATA_W-1:0] src1_data;
        logic                 src2_valid;
        logic [RS_TAG_W-1:0]  src2_tag;
        logic [RS_DATA_W-1:0] src2_data;
    } rs_entry_t;

    // Contents of the issue register handed to the functional unit.
    typedef struct packed {
        logic [RS_OP_W-1:0]   op;
        logic [RS_DATA_W-1:0] src1;
        logic [RS_DATA_W-1:0] src2;
        logic [RS_DATA_W-1:0] imm;
        logic [RS_DATA_W-1:0] pc;
        logic [RS_TAG_W-1:0]  des;
        logic                 bp;
    } rs_issue_t;

endpackage

// File: rtl/rs_age_pick.sv
// Age matrix for the station entries plus oldest-ready one-hot selection.
// age_q[i][j] set means entry i was dispatched before entry j.
module rs_age_pick
#(
    parameter int unsigned DEPTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DEPTH-1:0] alloc_oh_i,
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] pick_oh_o
);

    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    // New entry becomes younger than every live entry; its own row is cleared.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (alloc_oh_i[j]) begin
                    age_d[i][j] = valid_i[i] && (i != j);
                end
                if (alloc_oh_i[i]) begin
                    age_d[i][j] = 1'b0;
                end
            end
        end
    end

    // Age matrix register, frozen when the station is stalled.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst || clear_i) begin
                age_q[i] <= '0;
            end else if (en_i) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // A ready entry wins unless some other ready entry is older than it.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pick_oh_o[i] = ready_i[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((i != j) && ready_i[j] && age_q[j][i]) begin
                    pick_oh_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/param_rs.sv
// Parametrised reservation station: dispatch into lowest free slot, CDB
// wakeup with same-cycle bypass, oldest-ready issue into a held register.
module param_rs
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NCDB   = 4,
    parameter int unsigned TAG_W  = RS_TAG_W,
    parameter int unsigned DATA_W = RS_DATA_W,
    parameter int unsigned OP_W   = RS_OP_W
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [OP_W-1:0]        disp_op,
    input  logic [DATA_W-1:0]      disp_imm,
    input  logic [DATA_W-1:0]      disp_pc,
    input  logic [TAG_W-1:0]       disp_des,
    input  logic                   disp_bp,
    input  logic                   src1_valid,
    input  logic [TAG_W-1:0]       src1_tag,
    input  logic [DATA_W-1:0]      src1_data,
    input  logic                   src2_valid,
    input  logic [TAG_W-1:0]       src2_tag,
    input  logic [DATA_W-1:0]      src2_data,
    input  logic [NCDB-1:0]        cdb_en,
    input  logic [NCDB*TAG_W-1:0]  cdb_tag,
    input  logic [NCDB*DATA_W-1:0] cdb_data,
    output logic [$clog2(DEPTH):0] free_cnt,
    output logic                   iss_valid,
    input  logic                   iss_ready,
    output logic [OP_W-1:0]        iss_op,
    output logic [DATA_W-1:0]      iss_src1,
    output logic [DATA_W-1:0]      iss_src2,
    output logic [DATA_W-1:0]      iss_imm,
    output logic [DATA_W-1:0]      iss_pc,
    output logic [TAG_W-1:0]       iss_des,
    output logic                   iss_bp
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } cdb_hit_t;

    // Lowest-numbered enabled port carrying the tag supplies the data.
    function automatic cdb_hit_t cdb_lookup(input logic [TAG_W-1:0] tag,
                                            input logic [NCDB-1:0] en,
                                            input logic [NCDB*TAG_W-1:0] tags,
                                            input logic [NCDB*DATA_W-1:0] data);
        cdb_hit_t r;
        r = '0;
        for (int unsigned p = 0; p < NCDB; p++) begin
            if (!r.hit && en[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                r.hit  = 1'b1;
                r.data = data[p*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] alloc_oh, ready_vec, pick_oh;
    logic             alloc_found;
    logic [CNT_W-1:0] free_cnt_d;
    rs_entry_t        disp_ent, pick_ent;
    cdb_hit_t         byp1, byp2;
    logic             disp_fire, iss_load, iss_fire;
    logic             iss_valid_q, iss_valid_d;
    rs_issue_t        iss_q, iss_d;

    // Free-slot count, lowest free slot, and per-entry readiness.
    always_comb begin
        free_cnt_d  = '0;
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            free_cnt_d   = free_cnt_d + CNT_W'(!valid_q[i]);
            ready_vec[i] = valid_q[i] && ent_q[i].src1_valid && ent_q[i].src2_valid;
            if (!valid_q[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    assign free_cnt   = free_cnt_d;
    assign disp_ready = alloc_found;
    assign disp_fire  = disp_valid && disp_ready;
    assign iss_load   = !iss_valid_q || iss_ready;
    assign iss_fire   = iss_load && (|ready_vec);

    rs_age_pick #(.DEPTH(DEPTH)) u_age_pick (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .en_i      (rdy),
        .alloc_oh_i(alloc_oh & {DEPTH{disp_fire}}),
        .valid_i   (valid_q),
        .ready_i   (ready_vec),
        .pick_oh_o (pick_oh)
    );

    // Build the incoming entry, bypassing a same-cycle broadcast into it.
    always_comb begin
        byp1 = cdb_lookup(src1_tag, cdb_en, cdb_tag, cdb_data);
        byp2 = cdb_lookup(src2_tag, cdb_en, cdb_tag, cdb_data);
        disp_ent            = '0;
        disp_ent.op         = disp_op;
        disp_ent.imm        = disp_imm;
        disp_ent.pc         = disp_pc;
        disp_ent.des        = disp_des;
        disp_ent.bp         = disp_bp;
        disp_ent.src1_tag   = src1_tag;
        disp_ent.src1_valid = src1_valid || byp1.hit;
        disp_ent.src1_data  = src1_valid ? src1_data : byp1.data;
        disp_ent.src2_tag   = src2_tag;
        disp_ent.src2_valid = src2_valid || byp2.hit;
        disp_ent.src2_data  = src2_valid ? src2_data : byp2.data;
    end

    // Entry next state: wakeup, free on issue, allocate on dispatch.
    always_comb begin
        cdb_hit_t h1, h2;
        valid_d = valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            h1 = cdb_lookup(ent_q[i].src1_tag, cdb_en, cdb_tag, cdb_data);
            h2 = cdb_lookup(ent_q[i].src2_tag, cdb_en, cdb_tag, cdb_data);
            if (valid_q[i] && !ent_q[i].src1_valid && h1.hit) begin
                ent_d[i].src1_valid = 1'b1;
                ent_d[i].src1_data  = h1.data;
            end
            if (valid_q[i] && !ent_q[i].src2_valid && h2.hit) begin
                ent_d[i].src2_valid = 1'b1;
                ent_d[i].src2_data  = h2.data;
            end
            if (iss_fire && pick_oh[i]) begin
                valid_d[i] = 1'b0;
            end
            if (disp_fire && alloc_oh[i]) begin
                valid_d[i] = 1'b1;
                ent_d[i]   = disp_ent;
            end
        end
    end

    // Entry occupancy register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_q <= '0;
        end else if (rdy) begin
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; meaningful only where valid_q is set.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Mux the selected entry; an empty pick yields all-zero fields.
    always_comb begin
        pick_ent = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pick_oh[i]) begin
                pick_ent = ent_q[i];
            end
        end
        iss_valid_d = |ready_vec;
        iss_d.op    = pick_ent.op;
        iss_d.src1  = pick_ent.src1_data;
        iss_d.src2  = pick_ent.src2_data;
        iss_d.imm   = pick_ent.imm;
        iss_d.pc    = pick_ent.pc;
        iss_d.des   = pick_ent.des;
        iss_d.bp    = pick_ent.bp;
    end

    // Issue register: loads when empty or consumed, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else if (rdy && iss_load) begin
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_op    = iss_q.op;
    assign iss_src1  = iss_q.src1;
    assign iss_src2  = iss_q.src2;
    assign iss_imm   = iss_q.imm;
    assign iss_pc    = iss_q.pc;
    assign iss_des   = iss_q.des;
    assign iss_bp    = iss_q.bp;

endmodule

// File: doc/param_rs.md
PARAM_RS -- requirements
Module: param_rs

Interface
REQ-001 Parameter DEPTH, 8, number of entries (power of two, 2..32).
REQ-002 Parameter NCDB, 4, number of result broadcast ports.
REQ-003 Parameter TAG_W, 4, ROB tag width.
REQ-004 Parameter DATA_W, 32, operand/immediate/PC width.
REQ-005 Parameter OP_W, 6, opcode width.
REQ-006 Port clk input 1: clock; rst input 1: reset, synchronous, active-high.
REQ-007 Port rdy input 1: global enable; clear input 1: misprediction flush.
REQ-008 Port disp_valid input 1: dispatch request; disp_ready output 1: at least one free entry.
REQ-009 Ports disp_op/disp_imm/disp_pc/disp_des/disp_bp input OP_W/DATA_W/DATA_W/TAG_W/1: instruction fields.
REQ-010 Ports srcK_valid/srcK_tag/srcK_data (K=1,2) input 1/TAG_W/DATA_W: operand value or producer tag.
REQ-011 Ports cdb_en/cdb_tag/cdb_data input NCDB/NCDB*TAG_W/NCDB*DATA_W: packed broadcasts, port 0 at LSBs.
REQ-012 Port free_cnt output $clog2(DEPTH)+1: count of free entries.
REQ-013 Port iss_valid output 1; iss_ready input 1: issue handshake.
REQ-014 Ports iss_op/iss_src1/iss_src2/iss_imm/iss_pc/iss_des/iss_bp output: issued entry fields, registered.

Function
REQ-015 Dispatch SHALL write the lowest-index free entry when disp_valid and disp_ready; disp_valid while full SHALL be ignored, with no state change.
REQ-016 Wakeup: a waiting operand whose tag matches an enabled CDB port SHALL capture that data; the lowest port index wins on multiple matches.
REQ-017 Dispatch bypass: a dispatched operand invalid at input but matching an enabled CDB port in the same cycle SHALL be stored valid with the CDB data.
REQ-018 Selection SHALL pick the oldest (earliest-dispatched) entry with both operands valid; age is tracked by a DEPTH x DEPTH age matrix, not by index.
REQ-019 Issue register SHALL load when empty or when iss_valid and iss_ready; the selected entry is freed in the same cycle.
REQ-020 While iss_valid and not iss_ready, the issue register and all its outputs SHALL hold, and no entry is freed.
REQ-021 An entry dispatched with both operands ready at edge N SHALL be loaded into the issue register at edge N+1, if the register can load and the entry is oldest-ready.
REQ-022 An entry freed at edge N SHALL be allocatable by a dispatch at edge N+1; disp_ready and free_cnt reflect registered state only.
REQ-023 Simultaneous dispatch and issue in one cycle SHALL both proceed; free_cnt is unchanged.
REQ-024 clear SHALL invalidate all entries and drop iss_valid at the next edge, overriding dispatch and issue that cycle.
REQ-025 rdy low SHALL freeze all state, including CDB capture; rst and clear take effect regardless of rdy.
REQ-026 Issued data fields SHALL be zero whenever iss_valid is low.

Reset
REQ-027 On rst: all entries invalid, age matrix zero, iss_valid 0, all iss_* fields 0, free_cnt = DEPTH, disp_ready 1.
REQ-028 Reset mid-operation SHALL discard all pending and held-issue entries without output glitches beyond the reset edge.

Structure
REQ-029 Package rs_pkg SHALL hold the entry struct typedef (op, imm, pc, des, bp, src valid/tag/data) and the opcode-width constants shared with the ALU and LSB stations.
REQ-030 Sub-module rs_age_pick (age matrix update plus oldest-ready one-hot select, parametrised by DEPTH) SHALL be instantiated once.

Verification
REQ-031 Dispatch ready entries A, B, C in order, iss_ready=1 -> issue order A, B, C on consecutive cycles, each one cycle after dispatch.
REQ-032 Entry A waits on tag 5, B is ready; CDB port 2 broadcasts tag 5 data 0x1234 -> B issues first, then A with iss_src1=0x1234.
REQ-033 Dispatch with src1 tag 3 invalid while cdb port 0 broadcasts tag 3 data 0xAA -> entry issues next cycle with iss_src1=0xAA.
REQ-034 Fill DEPTH=8 entries -> disp_ready 0, free_cnt 0, and a ninth dispatch is dropped; issue one -> disp_ready 1 next cycle.
REQ-035 Hold iss_ready=0 for 3 cycles with iss_valid=1 -> outputs stable and free_cnt unchanged; release -> next oldest-ready entry issues.
REQ-036 Assert clear with 5 entries and iss_valid=1 -> next cycle iss_valid 0, free_cnt 8; tags 1,2 broadcast simultaneously on ports 1,0 -> port 0 data captured.
